// File: rtl/cmd_dispatch.sv
// -----------------------------------------------------------------------------
// cmd_dispatch
//
// Purpose:
//   UART command dispatcher. A received command byte selects one of NUM_CMD
//   attached handlers. The selected handler is then enabled and given the UART
//   transmitter until it reports completion or goes quiet for TIMEOUT cycles.
//   Unknown command bytes are answered with ERR_BYTE once the transmitter is
//   free.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   rx_ready     one-cycle receive strobe; rx_data valid while high
//   rx_data      received byte
//   tx_active    UART transmitter busy
//   tx_start     transmit start strobe
//   tx_data      byte to transmit; holds its last value when not driven
//   activate     one-hot handler enable
//   done         per-handler completion flags
//   h_tx_start   per-handler transmit strobes
//   h_tx_data    per-handler transmit bytes, handler i in [8i+7:8i]
//   busy         high whenever the dispatcher is not idle
//   timeout_err  one-cycle pulse when a handler is released by timeout
// -----------------------------------------------------------------------------
module cmd_dispatch #(
    parameter int          NUM_CMD  = 4,
    parameter logic [7:0]  CMD_BASE = 8'h01,
    parameter logic [7:0]  ERR_BYTE = 8'h3F,
    parameter logic [23:0] TIMEOUT  = 24'd10_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_ready,
    input  logic [7:0]             rx_data,
    input  logic                   tx_active,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [NUM_CMD-1:0]     activate,
    input  logic [NUM_CMD-1:0]     done,
    input  logic [NUM_CMD-1:0]     h_tx_start,
    input  logic [8*NUM_CMD-1:0]   h_tx_data,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ACTIVE   = 3'd1;
    localparam logic [2:0] ST_RELEASE  = 3'd2;
    localparam logic [2:0] ST_ERR_WAIT = 3'd3;
    localparam logic [2:0] ST_ERR_SEND = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [23:0]        cnt_q, cnt_d;
    logic               timeout_err_q, timeout_err_d;
    logic [7:0]         tx_hold_q;

    logic [NUM_CMD-1:0] sel_oh;
    logic               done_sel;
    logic               h_start_sel;
    logic [7:0]         h_data_sel;
    logic               cmd_valid;
    logic               cnt_clear;
    logic               cnt_hit;

    // One-hot view of the latched selection; used both as the enable vector
    // and as the mask for the per-handler inputs.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CMD; gi++) begin : g_sel_oh
            assign sel_oh[gi] = (sel_q == 3'(gi));
        end
    endgenerate

    assign done_sel    = |(done & sel_oh);
    assign h_start_sel = |(h_tx_start & sel_oh);

    always_comb begin
        h_data_sel = 8'h00;
        for (int i = 0; i < NUM_CMD; i++) begin
            if (sel_oh[i]) begin
                h_data_sel = h_tx_data[8*i +: 8];
            end
        end
    end

    // Range check is done in 9 bits so CMD_BASE+NUM_CMD never wraps past 8'hFF.
    assign cmd_valid = ({1'b0, rx_data} >= {1'b0, CMD_BASE}) &&
                       ({1'b0, rx_data} <  ({1'b0, CMD_BASE} + 9'(NUM_CMD)));

    // Activity from the host or the selected handler restarts the idle count.
    assign cnt_clear = rx_ready | h_start_sel;
    // "Reaches TIMEOUT" means the count would become TIMEOUT on this edge,
    // so a handler stays enabled for exactly TIMEOUT quiet cycles.
    assign cnt_hit   = !cnt_clear && (({1'b0, cnt_q} + 25'd1) >= {1'b0, TIMEOUT});

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 24'd0;
                if (rx_ready) begin
                    if (cmd_valid) begin
                        // Offset is below 8, so the low 3 bits suffice.
                        sel_d   = rx_data[2:0] - CMD_BASE[2:0];
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_ERR_WAIT;
                    end
                end
            end
            ST_ACTIVE: begin
                if (cnt_clear) begin
                    cnt_d = 24'd0;
                end else if (cnt_q < TIMEOUT) begin
                    cnt_d = cnt_q + 24'd1;
                end
                // Completion takes priority over a coincident timeout.
                if (done_sel) begin
                    state_d = ST_RELEASE;
                end else if (cnt_hit) begin
                    state_d       = ST_RELEASE;
                    timeout_err_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                cnt_d = 24'd0;
                if (!done_sel) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR_WAIT: begin
                if (!tx_active) begin
                    state_d = ST_ERR_SEND;
                end
            end
            ST_ERR_SEND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register so reset drops
    // activate without waiting for a clock edge.
    always_comb begin
        activate = '0;
        tx_start = 1'b0;
        tx_data  = tx_hold_q;
        case (state_q)
            ST_ACTIVE: begin
                activate = sel_oh;
                tx_start = h_start_sel;
                tx_data  = h_data_sel;
            end
            ST_ERR_SEND: begin
                tx_start = 1'b1;
                tx_data  = ERR_BYTE;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            sel_q         <= 3'd0;
            cnt_q         <= 24'd0;
            timeout_err_q <= 1'b0;
            tx_hold_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            tx_hold_q     <= tx_data;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
module tb_cmd_dispatch;

    logic        clk;
    logic        reset;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_active;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [3:0]  activate;
    logic [3:0]  done;
    logic [3:0]  h_tx_start;
    logic [31:0] h_tx_data;
    logic        busy;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    cmd_dispatch #(
        .NUM_CMD (4),
        .CMD_BASE(8'h01),
        .ERR_BYTE(8'h3F),
        .TIMEOUT (24'd100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .tx_active  (tx_active),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .activate   (activate),
        .done       (done),
        .h_tx_start (h_tx_start),
        .h_tx_data  (h_tx_data),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rr;
        logic [7:0]  rd;
        logic        ta;
        logic [3:0]  dn;
        logic [3:0]  hs;
        logic [31:0] hd;
        logic [3:0]  e_act;
        logic        e_txs;
        logic [7:0]  e_txd;
        logic        e_busy;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mkv(input logic rr, input logic [7:0] rd, input logic ta,
                                 input logic [3:0] dn, input logic [3:0] hs, input logic [31:0] hd,
                                 input logic [3:0] e_act, input logic e_txs, input logic [7:0] e_txd,
                                 input logic e_busy);
        vec_t v;
        v.rr = rr; v.rd = rd; v.ta = ta; v.dn = dn; v.hs = hs; v.hd = hd;
        v.e_act = e_act; v.e_txs = e_txs; v.e_txd = e_txd; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic rr, input logic [7:0] rd, input logic ta,
                         input logic [3:0] dn, input logic [3:0] hs, input logic [31:0] hd);
        rx_ready   = rr;
        rx_data    = rd;
        tx_active  = ta;
        done       = dn;
        h_tx_start = hs;
        h_tx_data  = hd;
    endtask

    // Unknown command followed by 'waits' cycles of a busy transmitter.
    task automatic err_seq(input logic [7:0] b, input int waits);
        @(negedge clk);
        drive(1'b1, b, 1'b1, 4'h0, 4'h0, 32'h0);
        #1 chk("err_cmd_busy", 32'(busy), 32'd0);
        for (int k = 0; k < waits; k++) begin
            @(negedge clk);
            if (k == 3) drive(1'b1, 8'h02, 1'b1, 4'h0, 4'h0, 32'h0);
            else        drive(1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 32'h0);
            #1;
            chk("err_wait_txs", 32'(tx_start), 32'd0);
            chk("err_wait_busy", 32'(busy), 32'd1);
            chk("err_wait_act", 32'(activate), 32'd0);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 32'h0);
        #1 chk("err_wait_last_txs", 32'(tx_start), 32'd0);
        @(negedge clk);
        #1;
        chk("err_send_txs", 32'(tx_start), 32'd1);
        chk("err_send_txd", 32'(tx_data), 32'h3F);
        @(negedge clk);
        #1;
        chk("err_after_txs", 32'(tx_start), 32'd0);
        chk("err_after_busy", 32'(busy), 32'd0);
        chk("err_after_txd", 32'(tx_data), 32'h3F);
        $display("err_seq byte=%02h waits=%0d done", b, waits);
    endtask

    // Activate handler 'cmd', optionally strobe it at cycle strobe_at and
    // raise its done from cycle done_at; count cycles with activate high.
    task automatic run_active(input logic [7:0] cmd, input int strobe_at, input int done_at,
                              input int exp_len, input logic exp_te);
        logic [3:0] oh;
        logic [3:0] hs;
        logic [3:0] dn;
        int len;
        int te_bad;
        oh = 4'b0001 << (cmd - 8'h01);
        @(negedge clk);
        drive(1'b1, cmd, 1'b0, 4'h0, 4'h0, 32'h0);
        #1 chk("run_cmd_busy", 32'(busy), 32'd0);
        len = 0;
        te_bad = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            hs = (i == strobe_at) ? oh : ((i == 30) ? ~oh : 4'h0);
            dn = (done_at > 0 && i >= done_at) ? oh : 4'h0;
            drive(1'b0, 8'h00, 1'b0, dn, hs, 32'h0);
            #1;
            if (activate !== oh) break;
            len++;
            if (timeout_err !== 1'b0) te_bad++;
        end
        chk("run_len", 32'(len), 32'(exp_len));
        chk("run_te_early", 32'(te_bad), 32'd0);
        chk("run_te_release", 32'(timeout_err), 32'(exp_te));
        chk("run_release_act", 32'(activate), 32'd0);
        chk("run_release_busy", 32'(busy), 32'd1);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 32'h0);
        #1;
        chk("run_te_after", 32'(timeout_err), 32'd0);
        chk("run_busy_after", 32'(busy), (done_at > 0) ? 32'd1 : 32'd0);
        if (done_at > 0) begin
            @(negedge clk);
            #1 chk("run_busy_final", 32'(busy), 32'd0);
        end
        $display("run_active cmd=%02h strobe_at=%0d done_at=%0d len=%0d", cmd, strobe_at, done_at, len);
    endtask

    initial begin
        vecs[0]  = mkv(0, 8'h00, 0, 4'h0, 4'h0, 32'h44332211, 4'h0, 0, 8'h00, 0);
        vecs[1]  = mkv(1, 8'h02, 0, 4'h0, 4'h0, 32'h44332211, 4'h0, 0, 8'h00, 0);
        vecs[2]  = mkv(0, 8'h00, 0, 4'h0, 4'h0, 32'h44332211, 4'h2, 0, 8'h22, 1);
        vecs[3]  = mkv(0, 8'h00, 0, 4'h0, 4'hD, 32'h44332211, 4'h2, 0, 8'h22, 1);
        vecs[4]  = mkv(0, 8'h00, 0, 4'h0, 4'h2, 32'h00005A00, 4'h2, 1, 8'h5A, 1);
        vecs[5]  = mkv(1, 8'h01, 0, 4'h0, 4'h0, 32'h44332211, 4'h2, 0, 8'h22, 1);
        vecs[6]  = mkv(0, 8'h00, 0, 4'h1, 4'h0, 32'h44332211, 4'h2, 0, 8'h22, 1);
        vecs[7]  = mkv(0, 8'h00, 0, 4'h2, 4'h0, 32'h44332211, 4'h2, 0, 8'h22, 1);
        vecs[8]  = mkv(0, 8'h00, 0, 4'h2, 4'h2, 32'h0000EE00, 4'h0, 0, 8'h22, 1);
        vecs[9]  = mkv(0, 8'h00, 0, 4'h0, 4'h0, 32'h0000EE00, 4'h0, 0, 8'h22, 1);
        vecs[10] = mkv(0, 8'h00, 0, 4'h0, 4'h0, 32'h0000EE00, 4'h0, 0, 8'h22, 0);
        vecs[11] = mkv(1, 8'h01, 0, 4'h0, 4'h0, 32'h0000EE00, 4'h0, 0, 8'h22, 0);
        vecs[12] = mkv(0, 8'h00, 0, 4'h0, 4'h3, 32'h000000A5, 4'h1, 1, 8'hA5, 1);
        vecs[13] = mkv(1, 8'h04, 0, 4'h0, 4'h0, 32'h00000000, 4'h1, 0, 8'h00, 1);
        vecs[14] = mkv(0, 8'h00, 0, 4'h1, 4'h0, 32'h00000000, 4'h1, 0, 8'h00, 1);
        vecs[15] = mkv(0, 8'h00, 0, 4'h0, 4'h0, 32'h00000000, 4'h0, 0, 8'h00, 1);
        vecs[16] = mkv(0, 8'h00, 0, 4'h0, 4'h0, 32'h00000000, 4'h0, 0, 8'h00, 0);

        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 32'h0);
        #1;
        chk("rst_act", 32'(activate), 32'd0);
        chk("rst_txs", 32'(tx_start), 32'd0);
        chk("rst_txd", 32'(tx_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_te", 32'(timeout_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 17; v++) begin
            @(negedge clk);
            drive(vecs[v].rr, vecs[v].rd, vecs[v].ta, vecs[v].dn, vecs[v].hs, vecs[v].hd);
            #1;
            chk($sformatf("vec%0d_act", v), 32'(activate), 32'(vecs[v].e_act));
            chk($sformatf("vec%0d_txs", v), 32'(tx_start), 32'(vecs[v].e_txs));
            chk($sformatf("vec%0d_txd", v), 32'(tx_data), 32'(vecs[v].e_txd));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].e_busy));
            chk($sformatf("vec%0d_te", v), 32'(timeout_err), 32'd0);
            $display("vec %0d act=%b txs=%b txd=%02h busy=%b", v, activate, tx_start, tx_data, busy);
        end

        err_seq(8'h7E, 10);
        err_seq(8'h00, 2);
        err_seq(8'h05, 0);

        run_active(8'h03, 0, 0, 100, 1'b1);
        run_active(8'h03, 60, 0, 160, 1'b1);
        run_active(8'h04, 0, 100, 100, 1'b0);
        run_active(8'h02, 0, 5, 5, 1'b0);

        // Reset in the middle of ACTIVE, away from any clock edge.
        @(negedge clk);
        drive(1'b1, 8'h01, 1'b0, 4'h0, 4'h0, 32'h0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 32'h0);
        #1 chk("mid_act_before", 32'(activate), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_act", 32'(activate), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_txd", 32'(tx_data), 32'h00);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_act", 32'(activate), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        drive(1'b1, 8'h02, 1'b0, 4'h0, 4'h0, 32'h0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 32'h0);
        #1 chk("post_rst_new_cmd", 32'(activate), 32'h2);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 4'h2, 4'h0, 32'h0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 32'h0);
        @(negedge clk);
        #1 chk("post_rst_idle", 32'(busy), 32'd0);
        $display("reset sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_dispatch.md
CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 Parameter NUM_CMD, default 4, SHALL set the number of attached command handlers (1..8).
REQ-002 Parameter CMD_BASE, default 8'h01, SHALL be the command byte that selects handler 0; byte CMD_BASE+i selects handler i.
REQ-003 Parameter ERR_BYTE, default 8'h3F, SHALL be the byte transmitted when an unknown command is received.
REQ-004 Parameter TIMEOUT, default 24'd10_000_000, SHALL be the inactivity limit in clk cycles for an active handler.
REQ-005 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-006 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 rx_ready  input  1  SHALL be the one-cycle UART receive strobe.
REQ-008 rx_data  input  8  SHALL be the received byte, valid while rx_ready=1.
REQ-009 tx_active  input  1  SHALL be high while the UART transmitter is busy.
REQ-010 tx_start  output  1  SHALL be the UART transmit start strobe.
REQ-011 tx_data  output  8  SHALL be the byte to transmit, valid while tx_start=1.
REQ-012 activate  output  NUM_CMD  SHALL be the one-hot handler enable; bit i drives handler i.
REQ-013 done  input  NUM_CMD  SHALL be the per-handler completion flags.
REQ-014 h_tx_start  input  NUM_CMD  SHALL be the per-handler transmit strobes.
REQ-015 h_tx_data  input  8*NUM_CMD  SHALL be the per-handler transmit bytes; handler i in bits [8i+7:8i].
REQ-016 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-017 timeout_err  output  1  SHALL pulse high for one cycle when a handler is released by timeout.

Function
REQ-018 The block SHALL implement states IDLE, ACTIVE, RELEASE, ERR_WAIT, ERR_SEND.
REQ-019 IDLE: on rx_ready with CMD_BASE <= rx_data < CMD_BASE+NUM_CMD, the block SHALL latch sel = rx_data-CMD_BASE (8-bit unsigned compare, no wrap) and enter ACTIVE next cycle.
REQ-020 IDLE: on rx_ready with any other rx_data the block SHALL enter ERR_WAIT.
REQ-021 The command byte SHALL be consumed by the dispatcher only; activate SHALL first rise the cycle after the rx_ready strobe, so the handler never sees the command byte.
REQ-022 ACTIVE: activate SHALL equal one-hot(sel); all other bits 0.
REQ-023 ACTIVE: tx_start and tx_data SHALL combinationally pass h_tx_start[sel] and h_tx_data[sel] (zero latency); unselected handler strobes SHALL be ignored.
REQ-024 ACTIVE: a cycle counter SHALL clear on entry and on every rx_ready or h_tx_start[sel], and otherwise increment, saturating at TIMEOUT.
REQ-025 ACTIVE: done[sel]=1 SHALL move to RELEASE next cycle; if done[sel]=1 and the counter reaches TIMEOUT in the same cycle, done wins and timeout_err SHALL stay 0.
REQ-026 ACTIVE: counter reaching TIMEOUT with done[sel]=0 SHALL move to RELEASE and pulse timeout_err for exactly one cycle.
REQ-027 RELEASE: activate SHALL be all zero, tx_start 0; the block SHALL return to IDLE once done[sel]=0.
REQ-028 rx_ready in ACTIVE, RELEASE, ERR_WAIT, ERR_SEND SHALL NOT be decoded as a command.
REQ-029 ERR_WAIT: on tx_active=0 the block SHALL enter ERR_SEND.
REQ-030 ERR_SEND: tx_start=1 and tx_data=ERR_BYTE for exactly one cycle, then IDLE.
REQ-031 Outside ACTIVE and ERR_SEND, tx_start SHALL be 0 and tx_data SHALL hold its last value.

Reset
REQ-032 reset=0 SHALL asynchronously force state IDLE, activate 0, tx_start 0, tx_data 8'h00, busy 0, timeout_err 0, counter 0, sel 0.
REQ-033 Reset asserted mid-operation SHALL drop activate immediately; after deassertion the block SHALL wait for a new command in IDLE.

Verification
REQ-034 rx 8'h02 -> activate=4'b0010 next cycle, busy=1; done[1]=1 -> activate=0 next cycle; done[1]=0 -> IDLE, busy=0.
REQ-035 In ACTIVE sel=0, h_tx_start[0]=1, h_tx_data[0]=8'hA5 (and h_tx_start[1]=1) -> tx_start=1, tx_data=8'hA5 same cycle.
REQ-036 rx 8'h7E with tx_active=1 for 10 cycles -> no tx_start until tx_active=0, then one-cycle tx_start with tx_data=8'h3F; back to IDLE.
REQ-037 TIMEOUT=100, activate handler 2, no activity -> after 100 cycles activate=0, timeout_err one-cycle pulse; done tied 0 -> IDLE next cycle.
REQ-038 rx 8'h04 while handler 0 active -> no change of activate; reset=0 mid-ACTIVE -> activate=0 without waiting for a clock edge.
